// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and elaboration-time helpers for the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int FIFO_READ_LATENCY_DEFAULT = 1;

  // Ceiling log2 for counter sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_buffer_fifo.sv
// Single-clock first-word-fall-through circular buffer; head word and valid come from registers only.
module stream_buffer_fifo
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH          = 160,
  parameter int BUF_DEPTH_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          push_data_i,
  input  logic                      pop_i,
  output logic                      out_valid_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [BUF_DEPTH_LOG2:0]   occupancy_o,
  output logic                      full_o
);

  localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int CW    = BUF_DEPTH_LOG2 + 1;
  localparam int PW    = BUF_DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);
  // At full a push only lands when the head leaves in the same cycle; otherwise it is dropped.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observable once count_q, which is reset, covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side companion for the dual-clock FIFO: credit-limited read requests, drain after reset,
// and a ready/valid re-presentation of returned words through a small local buffer.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH          = 160,
  parameter int READ_LATENCY   = FIFO_READ_LATENCY_DEFAULT,
  parameter int BUF_DEPTH_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic                      fifoReadEnable,
  input  logic                      fifoDataOutValid,
  input  logic [WIDTH-1:0]          fifoDataOut,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [WIDTH-1:0]          outData,
  output logic [BUF_DEPTH_LOG2:0]   occupancy,
  output logic                      overflowErr
);

  localparam int DEPTH   = 1 << BUF_DEPTH_LOG2;
  localparam int IF_W    = clog2(READ_LATENCY + 1) + 1;
  localparam int DRAIN_W = clog2(READ_LATENCY + 1);
  localparam int CRED_W  = ((IF_W > BUF_DEPTH_LOG2 + 1) ? IF_W : BUF_DEPTH_LOG2 + 1) + 2;

  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [READ_LATENCY-1:0] req_pipe_q, req_pipe_d;
  logic [IF_W-1:0]         in_flight_q, in_flight_d;
  logic                    overflow_q, overflow_d;
  logic                    draining, push_now, pop_now, retire, buf_full;
  logic [CRED_W-1:0]       credit_used;

  // Returns during the drain window belong to requests issued before reset and are discarded.
  assign draining = (drain_q != '0);
  assign push_now = fifoDataOutValid && !draining;
  assign pop_now  = outValid && outReady;
  assign retire   = req_pipe_q[READ_LATENCY-1];

  assign credit_used = CRED_W'(occupancy) + CRED_W'(in_flight_q)
                     + CRED_W'(push_now) - CRED_W'(pop_now);
  assign fifoReadEnable = !draining && (credit_used < CRED_W'(DEPTH));

  always_comb begin
    drain_d     = draining ? drain_q - DRAIN_W'(1) : drain_q;
    req_pipe_d  = READ_LATENCY'({req_pipe_q, fifoReadEnable});
    in_flight_d = in_flight_q + IF_W'(fifoReadEnable) - IF_W'(retire);
    overflow_d  = overflow_q | (push_now && buf_full && !pop_now);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drain_q     <= DRAIN_W'(READ_LATENCY);
      req_pipe_q  <= '0;
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      drain_q     <= drain_d;
      req_pipe_q  <= req_pipe_d;
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

  stream_buffer_fifo #(
    .WIDTH          (WIDTH),
    .BUF_DEPTH_LOG2 (BUF_DEPTH_LOG2)
  ) u_buffer (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push_now),
    .push_data_i (fifoDataOut),
    .pop_i       (pop_now),
    .out_valid_o (outValid),
    .out_data_o  (outData),
    .occupancy_o (occupancy),
    .full_o      (buf_full)
  );

  assign overflowErr = overflow_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized scoreboard bench: two readers (latency 1 and 3) share control; each has its own FIFO stub.
module tb_fifo_stream_reader;

  localparam int WIDTH    = 160;
  localparam int BUF_LOG2 = 2;
  localparam int DEPTH    = 1 << BUF_LOG2;

  logic clk       = 1'b0;
  logic resetn    = 1'b0;
  logic out_ready = 1'b1;
  int   stub_mode = 0;   // 0 FIFO empty, 1 always data, 2 random data, 3 returns ignoring credit
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int lat,
                       input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s (READ_LATENCY=%0d): got %0h, expected %0h", name, lat, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic                rd_en, o_valid, ovf;
    logic                f_vld = 1'b0;
    logic [WIDTH-1:0]    f_data = '0;
    logic [WIDTH-1:0]    o_data;
    logic [BUF_LOG2:0]   occ;
    logic [7:0]          rd_hist = '0;
    logic [WIDTH-1:0]    exp_q[$];
    int                  issues[$];
    int                  occ_m   = 0;
    int                  drain_m = LAT;
    int                  cyc     = 0;
    bit                  ovf_m   = 1'b0;

    fifo_stream_reader #(
      .WIDTH          (WIDTH),
      .READ_LATENCY   (LAT),
      .BUF_DEPTH_LOG2 (BUF_LOG2)
    ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .fifoReadEnable   (rd_en),
      .fifoDataOutValid (f_vld),
      .fifoDataOut      (f_data),
      .outValid         (o_valid),
      .outReady         (out_ready),
      .outData          (o_data),
      .occupancy        (occ),
      .overflowErr      (ovf)
    );

    // FIFO stub: answers a read LAT cycles later when it has data; mode 3 ignores credit entirely.
    always @(posedge clk) begin
      #2;
      case (stub_mode)
        0:       f_vld = 1'b0;
        1:       f_vld = rd_hist[LAT-1];
        2:       f_vld = rd_hist[LAT-1] && ($urandom_range(9) < 7);
        default: f_vld = 1'b1;
      endcase
      f_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end

    // Monitor: every accepted output word must be the oldest word the model expects.
    always @(negedge clk) begin
      if (o_valid && out_ready) begin
        check("scoreboard_nonempty", LAT, WIDTH'(exp_q.size() != 0), WIDTH'(1));
        if (exp_q.size() != 0) check("outData", LAT, o_data, exp_q.pop_front());
      end
    end

    // Reference model: counts and lists of outstanding requests, checked once per cycle.
    always @(negedge clk) begin
      bit drain_e, push_e, pop_e, rd_e, full_e;
      int infl;
      #1;
      drain_e = (drain_m > 0);
      push_e  = f_vld && !drain_e;
      pop_e   = (occ_m > 0) && out_ready;
      infl    = issues.size();
      rd_e    = !drain_e && (occ_m + infl + int'(push_e) - int'(pop_e) < DEPTH);
      full_e  = (occ_m == DEPTH);
      if (cyc > 0) begin
        check("fifoReadEnable", LAT, WIDTH'(rd_en), WIDTH'(rd_e));
        check("outValid", LAT, WIDTH'(o_valid), WIDTH'(occ_m != 0));
        check("occupancy", LAT, WIDTH'(occ), WIDTH'(occ_m));
        check("overflowErr", LAT, WIDTH'(ovf), WIDTH'(ovf_m));
      end
      rd_hist = {rd_hist[6:0], rd_en};
      if (!resetn) begin
        occ_m   = 0;
        drain_m = LAT;
        ovf_m   = 1'b0;
        issues.delete();
        exp_q.delete();
      end else begin
        if (drain_m > 0) drain_m--;
        if (rd_e) issues.push_back(cyc);
        while (issues.size() != 0 && issues[0] <= cyc - LAT + 1 - 1) void'(issues.pop_front());
        if (push_e) begin
          if (full_e && !pop_e) ovf_m = 1'b1;
          else begin
            exp_q.push_back(f_data);
            occ_m++;
          end
        end
        if (pop_e) occ_m--;
      end
      cyc++;
    end
  end

  task automatic run(input int n, input int mode, input int ready_pct);
    repeat (n) begin
      @(posedge clk);
      #1;
      stub_mode = mode;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    run(20, 0, 100);                 // empty FIFO: reads every cycle, nothing returned
    run(30, 1, 100);                 // continuous stream into a ready consumer
    run(20, 1, 0);                   // stall: buffer fills, reads stop
    run(10, 1, 100);                 // release: reads resume, order preserved
    run(300, 2, 60);
    run(8, 3, 0);                    // returns while full: dropped, sticky error
    run(20, 2, 50);
    do_reset(1);                     // reset with requests still in flight
    run(40, 1, 80);
    for (int i = 0; i < 4; i++) begin
      run(60, 2, 70);
      do_reset(1 + i % 2);
    end
    run(100, 2, 50);
    run(20, 0, 100);
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
